// File: rtl/m3_serial_tx.sv
// MSB-first serial transmitter with a per-bit strobe and a running mod-3 residue
// of the bits already sent, giving the golden value for the multiple-of-3 detector.
module m3_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             bit_tick,
  output logic             frame_done,
  output logic [1:0]       residue,
  output logic             exp_div3
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_INIT = BW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [CW-1:0]    cnt;
  logic [1:0]       res_q;
  logic             accept;
  logic             tick;

  // Residue kept in {0,1,2}; appending bit b to value v gives 2v+b.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    logic [1:0] nxt;
    case ({r, b})
      3'b000:  nxt = 2'd0;
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b011:  nxt = 2'd0;
      3'b100:  nxt = 2'd1;
      3'b101:  nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  assign accept = (state == IDLE) && load;
  assign tick   = (state == SHIFT) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (tick && (bitcnt == BW'(1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift, divider, bit counter and residue all advance together on the tick edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      cnt    <= '0;
      res_q  <= 2'd0;
    end else if (accept) begin
      shreg  <= din;
      bitcnt <= BIT_INIT;
      cnt    <= '0;
      res_q  <= 2'd0;
    end else if (state == SHIFT) begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        res_q  <= res_step(res_q, shreg[WIDTH-1]);
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt - BW'(1);
      end
    end
  end

  assign ready      = (state == IDLE);
  assign sout       = (state == SHIFT) && shreg[WIDTH-1];
  assign bit_tick   = tick;
  assign frame_done = (state == DONE);
  assign residue    = res_q;
  assign exp_div3   = (res_q == 2'd0);

endmodule

// File: tb/tb_m3_serial_tx.sv
// Bench for m3_serial_tx: DIV=4 and DIV=1 instances checked every cycle against
// a cycles-since-load model, plus literal expectations for known frames.
module tb_m3_serial_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, load4 = 1'b0;
  logic [7:0] din4 = 8'h00;
  logic       rdy4, so4, bt4, fd4, ex4;
  logic [1:0] rs4;

  logic       rst1 = 1'b0, load1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic       rdy1, so1, bt1, fd1, ex1;
  logic [1:0] rs1;

  int checks = 0;
  int errors = 0;

  m3_serial_tx #(.WIDTH(8), .DIV(4)) u_d4 (
    .clk(clk), .reset(rst4), .din(din4), .load(load4), .ready(rdy4), .sout(so4),
    .bit_tick(bt4), .frame_done(fd4), .residue(rs4), .exp_div3(ex4));

  m3_serial_tx #(.WIDTH(8), .DIV(1)) u_d1 (
    .clk(clk), .reset(rst1), .din(din1), .load(load1), .ready(rdy1), .sout(so1),
    .bit_tick(bt1), .frame_done(fd1), .residue(rs1), .exp_div3(ex1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: t = cycles since the accepting edge; t > W*d means idle.
  function automatic int m_sout(int t, int word, int d);
    if (t < W*d) return (word >> (W - 1 - t/d)) & 1;
    return 0;
  endfunction
  function automatic int m_tick(int t, int d);
    return (t < W*d && (t % d) == d - 1) ? 1 : 0;
  endfunction
  function automatic int m_res(int t, int word, int d);
    int bits;
    bits = (t < W*d) ? t/d : W;
    return (word >> (W - bits)) % 3;
  endfunction
  function automatic int m_ready(int t, int d);
    return (t > W*d) ? 1 : 0;
  endfunction
  function automatic int m_done(int t, int d);
    return (t == W*d) ? 1 : 0;
  endfunction

  int t4 = 33, w4 = 0;
  int t1 = 9,  w1 = 0;

  always @(posedge clk or negedge rst4) begin
    if (!rst4) begin
      t4 = 33; w4 = 0;
    end else if (t4 >= 33 && load4) begin
      t4 = 0; w4 = din4;
    end else if (t4 < 33) t4++;
  end

  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      t1 = 9; w1 = 0;
    end else if (t1 >= 9 && load1) begin
      t1 = 0; w1 = din1;
    end else if (t1 < 9) t1++;
  end

  always @(negedge clk) begin
    if (rst4) begin
      chk("d4_ready",      rdy4, m_ready(t4, 4));
      chk("d4_sout",       so4,  m_sout(t4, w4, 4));
      chk("d4_bit_tick",   bt4,  m_tick(t4, 4));
      chk("d4_frame_done", fd4,  m_done(t4, 4));
      chk("d4_residue",    rs4,  m_res(t4, w4, 4));
      chk("d4_exp_div3",   ex4,  (m_res(t4, w4, 4) == 0) ? 1 : 0);
    end
    if (rst1) begin
      chk("d1_ready",      rdy1, m_ready(t1, 1));
      chk("d1_sout",       so1,  m_sout(t1, w1, 1));
      chk("d1_bit_tick",   bt1,  m_tick(t1, 1));
      chk("d1_frame_done", fd1,  m_done(t1, 1));
      chk("d1_residue",    rs1,  m_res(t1, w1, 1));
      chk("d1_exp_div3",   ex1,  (m_res(t1, w1, 1) == 0) ? 1 : 0);
    end
  end

  task automatic send4(input logic [7:0] d);
    @(negedge clk);
    din4  = d;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
  endtask

  task automatic wait_tick4();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bt4 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("d4_tick_seen", ok, 1);
  endtask

  // res lists the residue after bit 0 first (leftmost).
  task automatic frame_lit(input logic [7:0] d, input logic [7:0][1:0] res);
    send4(d);
    for (int k = 0; k < 8; k++) begin
      wait_tick4();
      chk("lit_sout", so4, d[7-k]);
      @(negedge clk);
      chk("lit_residue", rs4, res[7-k]);
      chk("lit_exp_div3", ex4, (res[7-k] == 2'd0) ? 1 : 0);
    end
    chk("lit_frame_done", fd4, 1);
    chk("lit_ready_in_done", rdy4, 0);
    @(negedge clk);
    chk("lit_ready_back", rdy4, 1);
    chk("lit_done_cleared", fd4, 0);
  endtask

  task automatic lane4_seq();
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy4, 1);
    chk("rst_sout", so4, 0);
    chk("rst_exp_div3", ex4, 1);
    chk("rst_residue", rs4, 0);
    chk("rst_bit_tick", bt4, 0);
    chk("rst_frame_done", fd4, 0);
    rst4 = 1'b1;

    frame_lit(8'h09, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0});

    send4(8'h0A);
    n = 0;
    while (rdy4 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("h0a_ready_seen", rdy4, 1);
    chk("h0a_residue", rs4, 1);
    chk("h0a_exp_div3", ex4, 0);

    frame_lit(8'hFF, {2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0});

    // Busy load must be ignored; ready returns after E33.
    send4(8'h09);
    repeat (10) @(negedge clk);
    din4 = 8'h01;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    n = 0;
    while (rdy4 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("busy_ready_delay", n, 22);
    chk("busy_residue", rs4, 0);
    chk("busy_exp_div3", ex4, 1);

    // Asynchronous reset in the middle of a frame.
    send4(8'($urandom));
    for (int k = 0; k < 3; k++) wait_tick4();
    #2 rst4 = 1'b0;
    #1;
    chk("async_sout", so4, 0);
    chk("async_ready", rdy4, 1);
    chk("async_exp_div3", ex4, 1);
    chk("async_residue", rs4, 0);
    chk("async_bit_tick", bt4, 0);
    chk("async_frame_done", fd4, 0);
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    frame_lit(8'hFF, {2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0});

    // Random loads, including ones while busy and back-to-back frames.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din4  = 8'($urandom);
      load4 = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    load4 = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic lane1_seq();
    repeat (3) @(negedge clk);
    rst1  = 1'b1;
    din1  = 8'h03;
    load1 = 1'b1;
    for (int f = 0; f < 6; f++) begin
      din1 = (f % 2 == 0) ? 8'h03 : 8'h04;
      repeat (9) @(negedge clk);
      chk("d1_lit_frame_done", fd1, 1);
      chk("d1_lit_exp_div3", ex1, (f % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    load1 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    fork
      lane4_seq();
      lane1_seq();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
